// File: rtl/word_receiver_pkg.sv
// Shared sizes and state encoding for the JTAG word path.
// The capture side (word_receiver) and the transmit side take their word
// length and counter width from here so the two ends always agree.
package word_receiver_pkg;
  localparam int WORD_WIDTH = 32;
  localparam int WORD_CNT_W = 6;

  typedef enum logic {
    ST_IDLE  = 1'b0,  // count==0, no partial word held
    ST_SHIFT = 1'b1   // partial word in the shift register
  } rx_state_e;
endpackage

// File: rtl/word_receiver_if.sv
// Serial-in / word-out bus of the word receiver.
//   enable, in, ready : driven by the master (serial source + word consumer)
//   out, valid        : completed word and its handshake flag
//   overrun, count    : status (sticky drop flag, bits captured so far)
interface word_receiver_if
  import word_receiver_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int CNT_W = WORD_CNT_W
) ();
  logic             enable;
  logic             in;
  logic             ready;
  logic [WIDTH-1:0] out;
  logic             valid;
  logic             overrun;
  logic [CNT_W-1:0] count;

  modport master (output enable, in, ready, input out, valid, overrun, count);
  modport slave  (input enable, in, ready, output out, valid, overrun, count);
endinterface

// File: rtl/word_receiver_shift_in_reg.sv
// Left-shift capture register with synchronous clear and shift enable.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clr        : clear the held bits (has priority over shift_en)
//   shift_en   : shift 'in' into the LSB on this edge
//   in         : serial bit
//   word       : held bits with the current 'in' appended, i.e. the value the
//                register holds after a shift; this is the completed word on
//                the edge that samples the last bit.
// Only WIDTH-1 bits are stored: the oldest bit of a full word is never needed
// in the register because completion takes the live input bit directly.
module shift_in_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             in,
  output logic [WIDTH-1:0] word
);
  logic [WIDTH-2:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] shifted;

  assign shifted = {shreg_q, in};
  assign word    = shifted;

  always_comb begin
    shreg_d = shreg_q;
    if (clr)           shreg_d = '0;
    else if (shift_en) shreg_d = shifted[WIDTH-2:0];
  end

  always_ff @(posedge clk) begin
    if (reset) shreg_q <= '0;
    else       shreg_q <= shreg_d;
  end
endmodule

// File: rtl/word_receiver.sv
// Serial-to-parallel word receiver (capture side of the JTAG data path).
// Samples one bit per clock while enable is high, MSB first, and presents each
// completed WIDTH-bit word on a valid/ready handshake.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus.slave  : enable/in (serial input), out/valid/ready (word handshake),
//                overrun (sticky: a completed word was dropped),
//                count (bits captured in the current word, 0..WIDTH-1)
module word_receiver
  import word_receiver_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int CNT_W = WORD_CNT_W
) (
  input  logic           clk,
  input  logic           reset,
  word_receiver_if.slave bus
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  logic             last;      // this edge samples the WIDTH-th bit
  logic             complete;
  logic             shift_en;
  logic             sh_clr;
  logic [WIDTH-1:0] word;

  assign last     = (count_q == LAST);
  assign complete = bus.enable && last;

  shift_in_reg #(.WIDTH(WIDTH)) u_shreg (
    .clk      (clk),
    .reset    (reset),
    .clr      (sh_clr),
    .shift_en (shift_en),
    .in       (bus.in),
    .word     (word)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.enable) state_d = ST_SHIFT;
      ST_SHIFT: if (!bus.enable || last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs. Dropping enable always discards whatever partial word is
  // held; in IDLE the register is already empty of useful bits, so the clear
  // is harmless there too.
  always_comb begin
    shift_en = bus.enable;
    sh_clr   = !bus.enable;
  end

  // Bit counter wraps to 0 on completion so back-to-back words need no gap.
  always_comb begin
    count_d = '0;
    if (bus.enable && !last) count_d = count_q + CNT_W'(1);
  end

  // Output handshake. A completing edge may load a new word when the slot is
  // empty or being consumed on that same edge; otherwise the word is dropped.
  always_comb begin
    out_d     = out_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (complete) begin
      if (!valid_q || bus.ready) begin
        out_d   = word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && bus.ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.valid   = valid_q;
  assign bus.overrun = overrun_q;
  assign bus.count   = count_q;
endmodule
